spatz_tcdm_bank_responder: RTL
==============================

Name: spatz_tcdm_bank_responder

Overview:
Memory-side responder for one TCDM bank output of the cluster TCDM interconnect. It accepts bank requests (addr, write, amo, data, strb, user) and drives a single-port SRAM macro with 1-cycle read latency. It returns read data with the fixed 1-cycle latency that the interconnect's response shift register expects. Atomics (RISC-V AMO, LR/SC) execute as read-modify-write inside the bank, back-pressuring new requests for the write-back cycle.

Parameters:
AddrWidth, 10, word address width of the bank (SRAM depth = 2**AddrWidth)
DataWidth, 32, data width; only 32 is legal when AmoSupport=1
UserWidth, 1, user payload echoed with the response
AmoSupport, 1, 0: amo field ignored, treated as AMONone

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
q_valid_i  in  1  request valid
q_ready_o  out  1  request ready
q_addr_i  in  AddrWidth  word address within bank
q_write_i  in  1  1=write, 0=read
q_amo_i  in  4  atomic op code, see Behaviour
q_data_i  in  DataWidth  write data / AMO operand
q_strb_i  in  DataWidth/8  byte enables for plain writes
q_user_i  in  UserWidth  user payload
p_data_o  out  DataWidth  response data
p_user_o  out  UserWidth  echoed user of the responded request
p_valid_o  out  1  response valid, exactly 1 cycle after accept
sram_req_o  out  1  SRAM access enable
sram_we_o  out  1  SRAM write enable
sram_addr_o  out  AddrWidth  SRAM address
sram_wdata_o  out  DataWidth  SRAM write data
sram_be_o  out  DataWidth/8  SRAM byte enables
sram_rdata_i  in  DataWidth  SRAM read data, valid 1 cycle after read req

Behaviour:
- AMO codes: 0 None, 1 Swap, 2 Add, 3 And, 4 Or, 5 Xor, 6 Max, 7 Maxu, 8 Min, 9 Minu, 10 LR, 11 SC; 12-15 treated as None. Max/Min are signed 32-bit; Add wraps modulo 2^32.
- Accept = q_valid_i & q_ready_o. No response is dropped and there is no p-side back-pressure.
- Reset values: p_valid_o=0, p_data_o=0, p_user_o=0, all sram_* outputs 0, FSM=IDLE, reservation invalid.
- FSM IDLE:
  - q_ready_o=1.
  - On accept the SRAM is driven combinationally in the same cycle: sram_req_o=1, sram_addr_o=q_addr_i.
  - Plain write (amo=None, write=1): sram_we_o=1, be=q_strb_i, wdata=q_data_i.
  - Read, or any AMO other than SC: sram_we_o=0.
  - AMO in 1..9: go to AMO_WB.
- FSM AMO_WB (exactly one cycle):
  - q_ready_o=0.
  - sram_req_o=1, sram_we_o=1, be=all ones, addr=latched address.
  - wdata = op(sram_rdata_i, latched operand).
  - Return to IDLE.
- Latency: p_valid_o is asserted in the cycle after every accept, including writes (for those p_data_o is don't-care and driven with sram_rdata_i).
  - Read, LR and AMO: p_data_o = sram_rdata_i, i.e. the old value.
  - SC: p_data_o = 0 on success, 1 on failure.
  - p_user_o = user registered at accept.
- Reservation: single {valid, addr} register.
  - LR sets it to the request address.
  - SC succeeds iff valid & addr match. On success SC writes q_data_i with all byte enables in the accept cycle. SC always clears the reservation. SC never enters AMO_WB.
  - Any plain write, or AMO write-back, to the reserved address clears the reservation.
  - LR after LR overwrites the reservation.
- Throughput: 1 request/cycle for reads, writes, LR and SC. AMOs 1..9 take 2 cycles (one bubble).
- AmoSupport=0: AMO_WB is unreachable and LR/SC behave as plain reads/writes per q_write_i.
- Reset asserted mid-AMO: FSM returns to IDLE immediately and the write-back is lost. The pending p_valid_o is cleared and the reservation invalidated.
- q_valid_i low in IDLE: sram_req_o=0 and p_valid_o=0 next cycle.

Test Plan:
- Write addr 5 data 0xDEADBEEF strb 0xF, then read addr 5 -> p_valid_o 1 cycle after each accept; read returns 0xDEADBEEF.
- Addr 5 holds 0xDEADBEEF; write data 0x000000AA strb 0x1, read addr 5 -> 0xDEADBEAA.
- Addr 7 holds 10; AMO Add operand 5, with a read of addr 7 presented in the next cycle -> AMO response 10; q_ready_o=0 during AMO_WB; the read is accepted one cycle later and returns 15.
- Addr 3 holds 0xFFFFFFFF; AMO Max operand 1 -> response 0xFFFFFFFF, memory becomes 1. Then AMO Minu operand 0 -> response 1, memory becomes 0.
- LR addr 9, then SC addr 9 data 0x42 -> SC response 0 and memory 0x42. Repeat the SC -> response 1, memory unchanged. LR 9, plain write 9, SC 9 -> response 1.
- AMO Swap accepted, then rst_ni pulled low during AMO_WB -> after reset p_valid_o=0, q_ready_o=1, memory holds the pre-AMO value.

Source files
------------

// File: rtl/spatz_tcdm_bank_responder.sv
// TCDM bank responder: drives a 1-cycle single-port SRAM and executes AMO/LR/SC in-bank.
// Ports: q_* request side, p_* fixed 1-cycle response, sram_* macro interface.
module spatz_tcdm_bank_responder #(
    parameter int unsigned AddrWidth  = 10,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned UserWidth  = 1,
    parameter bit          AmoSupport = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   q_valid_i,
    output logic                   q_ready_o,
    input  logic [AddrWidth-1:0]   q_addr_i,
    input  logic                   q_write_i,
    input  logic [3:0]             q_amo_i,
    input  logic [DataWidth-1:0]   q_data_i,
    input  logic [DataWidth/8-1:0] q_strb_i,
    input  logic [UserWidth-1:0]   q_user_i,
    output logic [DataWidth-1:0]   p_data_o,
    output logic [UserWidth-1:0]   p_user_o,
    output logic                   p_valid_o,
    output logic                   sram_req_o,
    output logic                   sram_we_o,
    output logic [AddrWidth-1:0]   sram_addr_o,
    output logic [DataWidth-1:0]   sram_wdata_o,
    output logic [DataWidth/8-1:0] sram_be_o,
    input  logic [DataWidth-1:0]   sram_rdata_i
);

    localparam logic [3:0] AmoNone = 4'd0;
    localparam logic [3:0] AmoSwap = 4'd1;
    localparam logic [3:0] AmoAdd  = 4'd2;
    localparam logic [3:0] AmoAnd  = 4'd3;
    localparam logic [3:0] AmoOr   = 4'd4;
    localparam logic [3:0] AmoXor  = 4'd5;
    localparam logic [3:0] AmoMax  = 4'd6;
    localparam logic [3:0] AmoMaxu = 4'd7;
    localparam logic [3:0] AmoMin  = 4'd8;
    localparam logic [3:0] AmoMinu = 4'd9;
    localparam logic [3:0] AmoLr   = 4'd10;
    localparam logic [3:0] AmoSc   = 4'd11;

    typedef enum logic {IDLE, AMO_WB} state_e;

    state_e               state_q;
    logic [3:0]           amo_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] operand_q;
    logic                 res_valid_q;
    logic [AddrWidth-1:0] res_addr_q;
    logic                 sc_resp_q;
    logic                 sc_fail_q;

    logic [3:0]           amo_op;
    logic                 is_rmw;
    logic                 is_lr;
    logic                 is_sc;
    logic                 is_plain;
    logic                 accept;
    logic                 sc_ok;
    logic [DataWidth-1:0] amo_result;

    assign amo_op   = AmoSupport ? q_amo_i : AmoNone;
    assign is_rmw   = (amo_op >= AmoSwap) && (amo_op <= AmoMinu);
    assign is_lr    = (amo_op == AmoLr);
    assign is_sc    = (amo_op == AmoSc);
    assign is_plain = !(is_rmw || is_lr || is_sc);

    // Gated by reset so the SRAM sees no access while reset is held.
    assign q_ready_o = rst_ni && (state_q == IDLE);
    assign accept    = q_valid_i && q_ready_o;
    assign sc_ok     = res_valid_q && (res_addr_q == q_addr_i);

    always_comb begin
        amo_result = sram_rdata_i;
        unique case (amo_q)
            AmoSwap: amo_result = operand_q;
            AmoAdd:  amo_result = sram_rdata_i + operand_q;
            AmoAnd:  amo_result = sram_rdata_i & operand_q;
            AmoOr:   amo_result = sram_rdata_i | operand_q;
            AmoXor:  amo_result = sram_rdata_i ^ operand_q;
            AmoMax:  amo_result = ($signed(sram_rdata_i) > $signed(operand_q))
                                  ? sram_rdata_i : operand_q;
            AmoMaxu: amo_result = (sram_rdata_i > operand_q) ? sram_rdata_i : operand_q;
            AmoMin:  amo_result = ($signed(sram_rdata_i) < $signed(operand_q))
                                  ? sram_rdata_i : operand_q;
            AmoMinu: amo_result = (sram_rdata_i < operand_q) ? sram_rdata_i : operand_q;
            default: amo_result = sram_rdata_i;
        endcase
    end

    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        if (state_q == AMO_WB) begin
            // Old value arrives now; write back op(old, operand).
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = addr_q;
            sram_wdata_o = amo_result;
            sram_be_o    = '1;
        end else if (accept) begin
            sram_req_o  = 1'b1;
            sram_addr_o = q_addr_i;
            if (is_plain && q_write_i) begin
                sram_we_o    = 1'b1;
                sram_wdata_o = q_data_i;
                sram_be_o    = q_strb_i;
            end else if (is_sc && sc_ok) begin
                sram_we_o    = 1'b1;
                sram_wdata_o = q_data_i;
                sram_be_o    = '1;
            end
        end
    end

    // Writes return sram_rdata_i as don't-care data; SC returns its status.
    assign p_data_o = !p_valid_o ? '0 :
                      sc_resp_q  ? {{(DataWidth-1){1'b0}}, sc_fail_q} :
                                   sram_rdata_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            amo_q       <= AmoNone;
            addr_q      <= '0;
            operand_q   <= '0;
            res_valid_q <= 1'b0;
            res_addr_q  <= '0;
            sc_resp_q   <= 1'b0;
            sc_fail_q   <= 1'b0;
            p_valid_o   <= 1'b0;
            p_user_o    <= '0;
        end else begin
            p_valid_o <= accept;
            sc_resp_q <= accept && is_sc;
            sc_fail_q <= !sc_ok;
            if (accept) begin
                p_user_o <= q_user_i;
            end
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_rmw) begin
                            state_q   <= AMO_WB;
                            amo_q     <= amo_op;
                            addr_q    <= q_addr_i;
                            operand_q <= q_data_i;
                        end
                        if (is_lr) begin
                            res_valid_q <= 1'b1;
                            res_addr_q  <= q_addr_i;
                        end else if (is_sc) begin
                            res_valid_q <= 1'b0;
                        end else if (is_plain && q_write_i &&
                                     (q_addr_i == res_addr_q)) begin
                            res_valid_q <= 1'b0;
                        end
                    end
                end
                AMO_WB: begin
                    state_q <= IDLE;
                    if (addr_q == res_addr_q) begin
                        res_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
